rx_sample_monitor: RTL and testbench

//  Windowed statistics engine on the RX ADC sample stream. Its three stat words drive the

---
 rtl/rx_monitor_pkg.sv | 8 +
 rtl/rx_abs_sat.sv | 12 +
 rtl/rx_sample_monitor.sv | 92 +++++++++
 tb/tb_rx_sample_monitor.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/rx_monitor_pkg.sv
// rx_monitor_pkg: FSM state type and control-word field positions for rx_sample_monitor
package rx_monitor_pkg;
  typedef enum logic {IDLE, RUN} state_t;
  localparam int CTRL_EN_BIT = 0;
  localparam int CTRL_CLR_BIT = 1;
  localparam int CTRL_WIN_LSB = 8;
  localparam int CTRL_WIN_W = 24;
endpackage

// File: rtl/rx_abs_sat.sv
// rx_abs_sat: combinational saturating magnitude of a signed DW-bit value (x in, mag out)
module rx_abs_sat #(
  parameter int DW = 16
) (
  input  logic [DW-1:0] x,
  output logic [DW-1:0] mag
);
  logic [DW-1:0] neg;
  assign neg = -x;
  // only the most negative code negates back to itself with the sign bit still set
  assign mag = !x[DW-1] ? x : (neg[DW-1] ? {1'b0, {(DW-1){1'b1}}} : neg);
endmodule

// File: rtl/rx_sample_monitor.sv
// rx_sample_monitor: windowed peak/count statistics on the RX ADC I/Q stream
//   in:  clk, resetn (sync, active-low), adc_valid, adc_i, adc_q, ctrl {N[31:8], clear[1], enable[0]}
//   out: stat_total, stat_peak {clip_cnt, peak}, stat_windows, win_done
//   RX_SAMPLE_MONITOR_CLIP_COUNT_EN enables the per-window clip counter in stat_peak[31:16]
module rx_sample_monitor
  import rx_monitor_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter logic [15:0] CLIP_THRESH = 16'd32000
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  adc_valid,
  input  logic [DATA_WIDTH-1:0] adc_i,
  input  logic [DATA_WIDTH-1:0] adc_q,
  input  logic [31:0]           ctrl,
  output logic [31:0]           stat_total,
  output logic [31:0]           stat_peak,
  output logic [31:0]           stat_windows,
  output logic                  win_done
);
  state_t state, state_nxt;
  logic clr_hist, clr, run_req, accept, win_end, restart;
  logic [CTRL_WIN_W-1:0] win_n, win_last, cnt;
  logic [DATA_WIDTH-1:0] abs_i, abs_q, mag, acc_peak, peak_nxt;
  logic [15:0] clip_nxt;
  logic unused_ctrl;

  rx_abs_sat #(.DW(DATA_WIDTH)) u_abs_i (.x(adc_i), .mag(abs_i));
  rx_abs_sat #(.DW(DATA_WIDTH)) u_abs_q (.x(adc_q), .mag(abs_q));

  assign win_n = ctrl[CTRL_WIN_LSB +: CTRL_WIN_W];
  assign win_last = win_n - 24'd1;
  assign run_req = ctrl[CTRL_EN_BIT] && win_n != '0;
  assign clr = ctrl[CTRL_CLR_BIT] && !clr_hist;
  // >= rather than == so a shrunk N closes an over-long window on its next sample
  assign win_end = accept && cnt >= win_last;
  assign restart = clr || state != RUN || win_end;
  assign mag = abs_i > abs_q ? abs_i : abs_q;
  assign peak_nxt = mag > acc_peak ? mag : acc_peak;
  assign unused_ctrl = ^ctrl[7:2];

`ifdef RX_SAMPLE_MONITOR_CLIP_COUNT_EN
  logic [15:0] clip_cnt;
  logic clip_hit;
  assign clip_hit = 16'(abs_i) >= CLIP_THRESH || 16'(abs_q) >= CLIP_THRESH;
  assign clip_nxt = clip_cnt + ((clip_hit && clip_cnt != '1) ? 16'd1 : 16'd0);
  always_ff @(posedge clk)
    if (!resetn || restart) clip_cnt <= '0;
    else if (accept) clip_cnt <= clip_nxt;
`else
  logic unused_thresh;
  assign unused_thresh = ^CLIP_THRESH;
  assign clip_nxt = '0;
`endif

  always_ff @(posedge clk)
    if (!resetn) state <= IDLE;
    else state <= state_nxt;

  always_comb state_nxt = run_req ? RUN : IDLE;

  always_comb accept = adc_valid && state == RUN;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      clr_hist <= 1'b0;
      win_done <= 1'b0;
      stat_total <= '0;
      stat_peak <= '0;
      stat_windows <= '0;
      acc_peak <= '0;
      cnt <= '0;
    end else begin
      clr_hist <= ctrl[CTRL_CLR_BIT];
      win_done <= win_end && !clr;
      if (clr) begin
        stat_total <= '0;
        stat_peak <= '0;
        stat_windows <= '0;
      end else if (accept) begin
        stat_total <= stat_total + 32'd1;
        if (win_end) begin
          stat_peak <= {clip_nxt, 16'(peak_nxt)};
          stat_windows <= stat_windows + 32'd1;
        end
      end
      acc_peak <= restart ? '0 : (accept ? peak_nxt : acc_peak);
      cnt <= restart ? '0 : (accept ? cnt + 24'd1 : cnt);
    end
  end
endmodule

// File: tb/tb_rx_sample_monitor.sv
// tb_rx_sample_monitor: scoreboard bench for rx_sample_monitor
module tb_rx_sample_monitor;
`ifdef RX_SAMPLE_MONITOR_CLIP_COUNT_EN
  localparam bit CLIP_EN = 1'b1;
`else
  localparam bit CLIP_EN = 1'b0;
`endif
  typedef struct {
    logic [31:0] peak;
    logic [31:0] wins;
    logic [31:0] total;
  } exp_t;
  logic clk = 1'b0, resetn, adc_valid;
  logic [15:0] adc_i, adc_q;
  logic [31:0] ctrl, stat_total, stat_peak, stat_windows;
  logic win_done;
  exp_t sb[$];
  exp_t e;
  int n_chk = 0, n_err = 0, pulses = 0, pushed = 0;
  int m_n = 0, m_cnt = 0, m_peak = 0, m_clip = 0, m_total = 0, m_win = 0, p0;
  logic [31:0] m_last_peak = '0;
  bit m_run = 1'b0;

  rx_sample_monitor dut (
    .clk(clk), .resetn(resetn), .adc_valid(adc_valid), .adc_i(adc_i), .adc_q(adc_q),
    .ctrl(ctrl), .stat_total(stat_total), .stat_peak(stat_peak),
    .stat_windows(stat_windows), .win_done(win_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic int mag_of(input int v);
    int a = v < 0 ? -v : v;
    return a > 32767 ? 32767 : a;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ctrl(input logic [31:0] v);
    ctrl = v;
    m_n = int'(v[31:8]);
  endtask

  task automatic model_discard();
    m_cnt = 0;
    m_peak = 0;
    m_clip = 0;
  endtask

  task automatic model_clear();
    model_discard();
    m_total = 0;
    m_win = 0;
  endtask

  task automatic send(input int i, input int q);
    int mi = mag_of(i), mq = mag_of(q);
    adc_valid = 1'b1;
    adc_i = 16'(i);
    adc_q = 16'(q);
    if (m_run) begin
      m_total++;
      if (mi > m_peak) m_peak = mi;
      if (mq > m_peak) m_peak = mq;
      if (CLIP_EN && (mi >= 32000 || mq >= 32000) && m_clip < 65535) m_clip++;
      if (m_cnt >= m_n - 1) begin
        m_win++;
        m_last_peak = {16'(m_clip), 16'(m_peak)};
        sb.push_back('{peak: m_last_peak, wins: 32'(m_win), total: 32'(m_total)});
        pushed++;
        model_discard();
      end else m_cnt++;
    end
    cyc();
    adc_valid = 1'b0;
  endtask

  task automatic do_clear();
    ctrl = ctrl | 32'h2;
    cyc();
    ctrl = ctrl & ~32'h2;
    model_clear();
    cyc();
  endtask

  always @(negedge clk)
    if (resetn && win_done) begin
      pulses++;
      if (sb.size() == 0) check("sb_unexpected", 32'd1, 32'd0);
      else begin
        e = sb.pop_front();
        check("sb_peak", stat_peak, e.peak);
        check("sb_windows", stat_windows, e.wins);
        check("sb_total", stat_total, e.total);
      end
    end

  initial begin
    resetn = 1'b0;
    adc_valid = 1'b0;
    adc_i = '0;
    adc_q = '0;
    set_ctrl(32'h0);
    repeat (3) cyc();
    check("rst_total", stat_total, 32'd0);
    check("rst_peak", stat_peak, 32'd0);
    check("rst_windows", stat_windows, 32'd0);
    check("rst_done", {31'd0, win_done}, 32'd0);
    resetn = 1'b1;
    set_ctrl(32'h0000_0401);
    cyc();
    m_run = 1'b1;
    send(100, 0);
    send(-300, 0);
    send(5, 0);
    send(-32768, 0);
    check("t1_done", {31'd0, win_done}, 32'd1);
    check("t1_peak", stat_peak, CLIP_EN ? 32'h0001_7FFF : 32'h0000_7FFF);
    check("t1_windows", stat_windows, 32'd1);
    check("t1_total", stat_total, 32'd4);
    cyc();
    check("t1_pulse_once", {31'd0, win_done}, 32'd0);
    do_clear();
    check("clr_total", stat_total, 32'd0);
    set_ctrl(32'h0000_0301);
    p0 = pulses;
    for (int k = 0; k < 9; k++) begin
      send(k * 10 + 1, -k);
      cyc();
    end
    check("t2_windows", stat_windows, 32'd3);
    check("t2_total", stat_total, 32'd9);
    check("t2_pulses", 32'(pulses - p0), 32'd3);
    set_ctrl(32'h0000_0401);
    send(900, 0);
    send(1, 1);
    set_ctrl(32'h0000_0400);
    m_run = 1'b0;
    model_discard();
    repeat (3) cyc();
    send(5000, 5000);
    send(6000, 6000);
    check("t3_hold_total", stat_total, 32'(m_total));
    check("t3_hold_windows", stat_windows, 32'(m_win));
    check("t3_hold_peak", stat_peak, m_last_peak);
    check("t3_hold_done", {31'd0, win_done}, 32'd0);
    set_ctrl(32'h0000_0401);
    cyc();
    m_run = 1'b1;
    send(3, 0);
    send(-7, 2);
    send(2, -1);
    send(0, 0);
    check("t3_peak", stat_peak, 32'd7);
    cyc();
    send(1, 0);
    send(2, 0);
    send(3, 0);
    ctrl = 32'h0000_0403;
    adc_valid = 1'b1;
    adc_i = 16'd100;
    adc_q = 16'd0;
    cyc();
    adc_valid = 1'b0;
    model_clear();
    check("t4_total", stat_total, 32'd0);
    check("t4_peak", stat_peak, 32'd0);
    check("t4_windows", stat_windows, 32'd0);
    check("t4_done", {31'd0, win_done}, 32'd0);
    send(10, 0);
    send(20, 0);
    send(30, 0);
    send(40, 0);
    check("t4_held_windows", stat_windows, 32'd1);
    check("t4_held_total", stat_total, 32'd4);
    set_ctrl(32'h0000_0001);
    cyc();
    m_run = 1'b0;
    model_discard();
    cyc();
    send(11, 11);
    send(12, 12);
    send(13, 13);
    check("t5_frozen_total", stat_total, 32'(m_total));
    check("t5_frozen_windows", stat_windows, 32'(m_win));
    set_ctrl(32'h0000_0401);
    cyc();
    m_run = 1'b1;
    send(4, 0);
    send(5, 0);
    send(6, 0);
    set_ctrl(32'h0000_0201);
    cyc();
    send(50, 0);
    check("t7_shrink_done", {31'd0, win_done}, 32'd1);
    cyc();
    do_clear();
    set_ctrl(32'h0000_0501);
    cyc();
    send(32000, 0);
    send(-32001, 0);
    send(31999, 0);
    send(0, 0);
    send(-32768, 0);
    check("t6_peak", stat_peak, CLIP_EN ? 32'h0003_7FFF : 32'h0000_7FFF);
    repeat (2) cyc();
    check("sb_drained", 32'(sb.size()), 32'd0);
    check("pulse_count", 32'(pulses), 32'(pushed));
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
